// File: rtl/riscv_instr_classifier.sv
// Elastic pipelined RV32I/RV64I instruction classifier with optional retire statistics.
// Statistics counters exist only when RISCV_CLASSIFIER_STATS_EN is defined.
module riscv_instr_classifier #(
   parameter int XLEN       = 32,
   parameter int PIPE_DEPTH = 2,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [XLEN-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [3:0]       out_fmt,
   output logic [15:0]      out_cat,
   output logic [4:0]       out_rd,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic [XLEN-1:0]  out_imm,
   output logic             out_illegal,
   input  logic [4:0]       stat_sel,
   output logic [CNT_W-1:0] stat_count,
   input  logic             stat_clr
);

   localparam bit IS64 = (XLEN == 64);

   typedef enum logic [3:0] {
      FMT_J       = 4'd0,
      FMT_U       = 4'd1,
      FMT_I       = 4'd2,
      FMT_I_SHIFT = 4'd3,
      FMT_B       = 4'd4,
      FMT_R       = 4'd5,
      FMT_S       = 4'd6
   } fmt_e;

   localparam logic [15:0] CAT_LOAD    = 16'h0001;
   localparam logic [15:0] CAT_STORE   = 16'h0002;
   localparam logic [15:0] CAT_SHIFT   = 16'h0004;
   localparam logic [15:0] CAT_ARITH   = 16'h0008;
   localparam logic [15:0] CAT_LOGICAL = 16'h0010;
   localparam logic [15:0] CAT_COMPARE = 16'h0020;
   localparam logic [15:0] CAT_BRANCH  = 16'h0040;
   localparam logic [15:0] CAT_JUMP    = 16'h0080;
   localparam logic [15:0] CAT_SYNCH   = 16'h0100;
   localparam logic [15:0] CAT_SYSTEM  = 16'h0200;
   localparam logic [15:0] CAT_CSR     = 16'h0800;
   localparam logic [15:0] CAT_TRAP    = 16'h2000;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_OP32   = 7'b0111011;
   localparam logic [6:0] OP_MISC   = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [3:0]      fmt;
      logic [15:0]     cat;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [XLEN-1:0] imm;
      logic            illegal;
   } res_t;

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      return XLEN'($signed(v));
   endfunction

   // Shared ALU category for OP/OP-IMM families, keyed by funct3 only.
   function automatic logic [15:0] aluCat(input logic [2:0] f3);
      logic [15:0] c;
      case (f3)
         3'd0:                c = CAT_ARITH;
         3'd1, 3'd5:          c = CAT_SHIFT;
         3'd2, 3'd3:          c = CAT_COMPARE;
         default:             c = CAT_LOGICAL;
      endcase
      return c;
   endfunction

   function automatic logic fullFrom(input logic [PIPE_DEPTH-1:0] v, input int idx);
      logic full;
      full = 1'b1;
      for (int j = 0; j < PIPE_DEPTH; j++) begin
         if (j >= idx) full = full & v[j];
      end
      return full;
   endfunction

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [3:0]      decFmt;
   logic [15:0]     decCat;
   logic [XLEN-1:0] decImm;
   logic            useRd, useRs1, useRs2, legal;
   res_t            dec;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];

   always_comb begin
      decFmt = FMT_J;
      decCat = '0;
      decImm = '0;
      useRd  = 1'b0;
      useRs1 = 1'b0;
      useRs2 = 1'b0;
      legal  = 1'b1;
      case (opcode)
         OP_LUI, OP_AUIPC: begin
            decFmt = FMT_U;
            decCat = CAT_ARITH;
            useRd  = 1'b1;
            decImm = sext32({in_instr[31:12], 12'b0});
         end
         OP_JAL: begin
            decFmt = FMT_J;
            decCat = CAT_JUMP;
            useRd  = 1'b1;
            decImm = sext32({{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0});
         end
         OP_JALR: begin
            legal  = (funct3 == 3'd0);
            decFmt = FMT_I;
            decCat = CAT_JUMP;
            useRd  = 1'b1;
            useRs1 = 1'b1;
            decImm = sext32({{20{in_instr[31]}}, in_instr[31:20]});
         end
         OP_BRANCH: begin
            legal  = (funct3 != 3'd2) && (funct3 != 3'd3);
            decFmt = FMT_B;
            decCat = CAT_BRANCH;
            useRs1 = 1'b1;
            useRs2 = 1'b1;
            decImm = sext32({{19{in_instr[31]}}, in_instr[31], in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0});
         end
         OP_LOAD: begin
            case (funct3)
               3'd0, 3'd1, 3'd2, 3'd4, 3'd5: legal = 1'b1;
               3'd3, 3'd6:                   legal = IS64;
               default:                      legal = 1'b0;
            endcase
            decFmt = FMT_I;
            decCat = CAT_LOAD;
            useRd  = 1'b1;
            useRs1 = 1'b1;
            decImm = sext32({{20{in_instr[31]}}, in_instr[31:20]});
         end
         OP_STORE: begin
            legal  = (funct3 <= 3'd2) || ((funct3 == 3'd3) && IS64);
            decFmt = FMT_S;
            decCat = CAT_STORE;
            useRs1 = 1'b1;
            useRs2 = 1'b1;
            decImm = sext32({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
         end
         OP_IMM: begin
            useRd  = 1'b1;
            useRs1 = 1'b1;
            decCat = aluCat(funct3);
            if (funct3 == 3'd1 || funct3 == 3'd5) begin
               // shamt[5] lives in funct7[0]; it is only meaningful on RV64
               legal  = ((in_instr[31:26] == 6'b000000) ||
                         ((funct3 == 3'd5) && (in_instr[31:26] == 6'b010000))) &&
                        (IS64 || !in_instr[25]);
               decFmt = FMT_I_SHIFT;
               decImm = XLEN'(in_instr[25:20]);
            end else begin
               decFmt = FMT_I;
               decImm = sext32({{20{in_instr[31]}}, in_instr[31:20]});
            end
         end
         OP_IMM32: begin
            useRd  = 1'b1;
            useRs1 = 1'b1;
            decCat = aluCat(funct3);
            case (funct3)
               3'd0: begin
                  legal  = IS64;
                  decFmt = FMT_I;
                  decImm = sext32({{20{in_instr[31]}}, in_instr[31:20]});
               end
               3'd1, 3'd5: begin
                  legal  = IS64 && ((funct7 == 7'b0000000) ||
                                    ((funct3 == 3'd5) && (funct7 == 7'b0100000)));
                  decFmt = FMT_I_SHIFT;
                  decImm = XLEN'(in_instr[24:20]);
               end
               default: legal = 1'b0;
            endcase
         end
         OP_OP, OP_OP32: begin
            decFmt = FMT_R;
            decCat = aluCat(funct3);
            useRd  = 1'b1;
            useRs1 = 1'b1;
            useRs2 = 1'b1;
            if (funct7 == 7'b0000000)
               legal = (opcode == OP_OP) || (funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd5);
            else if (funct7 == 7'b0100000)
               legal = (funct3 == 3'd0) || (funct3 == 3'd5);
            else
               legal = 1'b0;
            if (opcode == OP_OP32 && !IS64) legal = 1'b0;
         end
         OP_MISC: begin
            legal  = (funct3 == 3'd0) || (funct3 == 3'd1);
            decFmt = FMT_I;
            decCat = CAT_SYNCH;
            useRd  = 1'b1;
            useRs1 = 1'b1;
            decImm = sext32({{20{in_instr[31]}}, in_instr[31:20]});
         end
         OP_SYSTEM: begin
            decFmt = FMT_I;
            useRd  = 1'b1;
            useRs1 = 1'b1;
            decImm = sext32({{20{in_instr[31]}}, in_instr[31:20]});
            if (funct3 == 3'd0) begin
               legal  = (in_instr[31:20] == 12'd0) || (in_instr[31:20] == 12'd1);
               decCat = CAT_SYSTEM | CAT_TRAP;
            end else begin
               legal  = (funct3 != 3'd4);
               decCat = CAT_CSR;
            end
         end
         default: legal = 1'b0;
      endcase
      if (in_instr[1:0] != 2'b11) legal = 1'b0;

      // Illegal words keep only the PC so downstream can still locate them.
      dec         = '0;
      dec.pc      = in_pc;
      dec.illegal = !legal;
      if (legal) begin
         dec.fmt = decFmt;
         dec.cat = decCat;
         dec.rd  = useRd  ? in_instr[11:7]  : 5'd0;
         dec.rs1 = useRs1 ? in_instr[19:15] : 5'd0;
         dec.rs2 = useRs2 ? in_instr[24:20] : 5'd0;
         dec.imm = decImm;
      end
   end

   logic [PIPE_DEPTH-1:0] stageValid_q, stageValid_d;
   logic [PIPE_DEPTH-1:0] stageReady;
   res_t                  stage_q [PIPE_DEPTH];
   res_t                  stage_d [PIPE_DEPTH];
   res_t                  outStage;

   // A stage can take a new word unless it and every stage after it are full and the sink stalls.
   always_comb begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
         stageReady[k] = out_ready | ~fullFrom(stageValid_q, k);
      end
   end

   always_comb begin
      stageValid_d = stageValid_q;
      for (int k = 0; k < PIPE_DEPTH; k++) stage_d[k] = stage_q[k];
      if (stageReady[0]) begin
         stageValid_d[0] = in_valid;
         if (in_valid) stage_d[0] = dec;
      end
      for (int k = 1; k < PIPE_DEPTH; k++) begin
         if (stageReady[k]) begin
            stageValid_d[k] = stageValid_q[k-1];
            if (stageValid_q[k-1]) stage_d[k] = stage_q[k-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stageValid_q <= '0;
         for (int k = 0; k < PIPE_DEPTH; k++) stage_q[k] <= '0;
      end else begin
         stageValid_q <= stageValid_d;
         for (int k = 0; k < PIPE_DEPTH; k++) stage_q[k] <= stage_d[k];
      end
   end

   // Handshakes are masked during reset so nothing is accepted or emitted and then lost.
   assign outStage    = stage_q[PIPE_DEPTH-1];
   assign in_ready    = stageReady[0] & ~rst;
   assign out_valid   = stageValid_q[PIPE_DEPTH-1] & ~rst;
   assign out_pc      = outStage.pc;
   assign out_fmt     = outStage.fmt;
   assign out_cat     = outStage.cat;
   assign out_rd      = outStage.rd;
   assign out_rs1     = outStage.rs1;
   assign out_rs2     = outStage.rs2;
   assign out_imm     = outStage.imm;
   assign out_illegal = outStage.illegal;

`ifdef RISCV_CLASSIFIER_STATS_EN
   logic [CNT_W-1:0] statCnt_q [17];
   logic [CNT_W-1:0] statCnt_d [17];
   logic [16:0]      incMask;
   logic             outXfer;

   assign outXfer = out_valid & out_ready;
   assign incMask = {outStage.illegal, outStage.cat};

   // Saturating counters; a clear overrides any increment in the same cycle.
   always_comb begin
      for (int k = 0; k < 17; k++) begin
         statCnt_d[k] = statCnt_q[k];
         if (stat_clr)
            statCnt_d[k] = '0;
         else if (outXfer && incMask[k] && !(&statCnt_q[k]))
            statCnt_d[k] = statCnt_q[k] + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 17; k++) statCnt_q[k] <= '0;
      end else begin
         for (int k = 0; k < 17; k++) statCnt_q[k] <= statCnt_d[k];
      end
   end

   always_comb begin
      stat_count = '0;
      if (stat_sel <= 5'd16) stat_count = statCnt_q[stat_sel];
   end
`else
   logic unusedStat;
   assign unusedStat = ^{stat_sel, stat_clr};
   assign stat_count = '0;
`endif

endmodule

// File: doc/riscv_instr_classifier.md
Name: riscv_instr_classifier

Overview:
- Elastic, pipelined classifier for RV32I/RV64I instruction words.
- Decodes each word into the team's format encoding, category bitmask, register fields and sign-extended immediate, with per-category retire statistics.
- Sits between the instruction-stream monitor/fetch model and the coverage and scoreboard logic.
- Generalised in XLEN and pipeline depth; adds illegal-instruction detection and statistics.

Parameters:
- XLEN, 32, data width; 32 or 64. 64 enables OP-IMM-32, OP-32, LWU, LD, SD and 6-bit shamt.
- PIPE_DEPTH, 2, number of registered stages; 1..3.
- CNT_W, 32, statistics counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  classifier can accept
- in_instr  in  32  instruction word
- in_pc  in  XLEN  PC of the word
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_pc  out  XLEN  PC passed through
- out_fmt  out  4  format code: J=0 U=1 I=2 I_SHIFT=3 B=4 R=5 S=6
- out_cat  out  16  category bitmask: LOAD=bit0 … AMO=bit15
- out_rd, out_rs1, out_rs2  out  5 each  register fields; 0 if unused by the format
- out_imm  out  XLEN  sign-extended immediate; shamt zero-extended; 0 for R
- out_illegal  out  1  word not legal for XLEN
- stat_sel  in  5  counter select: 0..15 category, 16 illegal
- stat_count  out  CNT_W  selected counter
- stat_clr  in  1  clear all counters

Behaviour:
- Reset: out_valid=0; in_ready=1 on the cycle after rst deasserts; all stage-valid bits and counters cleared; data outputs 0.
- Handshake: transfer on valid&ready at each port.
- Each stage loads when empty or when its downstream stage transfers.
- in_ready = first stage empty OR first stage advancing (combinational from out_ready through the chain); no bubbles.
- Throughput 1 word/cycle.
- Latency: exactly PIPE_DEPTH cycles from input transfer to out_valid when out_ready is held high.
- Backpressure: while out_valid & ~out_ready, all out_* are stable and no word is dropped or duplicated. Words leave in order.
- Category mapping:
  - LUI, AUIPC, ADD*, SUB* → ARITHMETIC (0x0008).
  - SLT*/SLTI* → COMPARE (0x0020).
  - XOR/OR/AND(I) → LOGICAL (0x0010).
  - SLL/SRL/SRA(I)(W) → SHIFT (0x0004).
  - Loads → LOAD (0x0001); stores → STORE (0x0002).
  - Branches → BRANCH (0x0040); JAL/JALR → JUMP (0x0080).
  - FENCE/FENCE.I → SYNCH (0x0100).
  - ECALL/EBREAK → SYSTEM|TRAP (0x2200).
  - CSRR* → CSR (0x0800).
- Format mapping:
  - JAL=J; LUI/AUIPC=U; loads/JALR/OP-IMM non-shift/FENCE/SYSTEM=I.
  - Immediate shifts=I_SHIFT; branches=B; OP/OP-32=R; stores=S.
- Illegal conditions:
  - in_instr[1:0]≠2'b11.
  - Unknown opcode, or undefined funct3/funct7 combination.
  - XLEN=32 and (shamt[5]=1, RV64-only opcode, LWU/LD/SD).
  - SYSTEM funct3=0 with imm other than 0/1.
- Illegal result: out_illegal=1, out_cat=0, out_fmt=0, register fields and imm=0, PC passed through.
- Statistics:
  - On each output transfer, every counter whose bit is set in out_cat increments; counter 16 increments if out_illegal.
  - Counters saturate at all-ones.
  - stat_clr zeroes all counters next cycle; clr wins over a same-cycle increment.
  - stat_count is a combinational mux of registered counters; stat_sel>16 returns 0.
- Reset mid-operation: in-flight words discarded, no output transfer that cycle.

Optional Feature:
- Macro: RISCV_CLASSIFIER_STATS_EN.
- Defined: counters and stat_* behaviour as above.
- Undefined: no counter registers; stat_count tied to 0; stat_sel and stat_clr ignored. The pipeline is unchanged.

Test Plan:
- 0x00500093 (ADDI x1,x0,5), out_ready=1, PIPE_DEPTH=2 → out_valid exactly 2 cycles later; fmt=2, cat=0x0008, rd=1, rs1=0, imm=5, illegal=0.
- 0xFE0008E3 (BEQ x0,x0,-16) → fmt=4, cat=0x0040, rs1=rs2=0, imm=0xFFFFFFF0 (XLEN=32) / 0xFFFFFFFFFFFFFFF0 (XLEN=64).
- 0x02009093 (SLLI x1,x1,32) → XLEN=32: illegal=1, cat=0. XLEN=64: fmt=3, cat=0x0004, imm=32.
- Stream of 8 back-to-back words with out_ready toggling 1,0,0,1,… → all 8 emerge in order; outputs stable during stalls; in_ready drops only when all stages are full.
- With STATS_EN: 3 ADDI, 1 ECALL (0x00000073), 1 word 0x00000000 → stat_sel=3 reads 3; sel=9 and sel=13 read 1; sel=16 reads 1. Assert stat_clr on the same cycle as an increment → reads 0.
- Assert rst with 2 words in flight → out_valid=0 the next cycle, neither word emitted, counters 0, in_ready=1.
